muldiv_controller: RTL and testbench



---
 rtl/muldiv_pkg.sv | 15 +
 rtl/muldiv_controller_if.sv | 19 +
 rtl/div_step.sv | 18 +
 rtl/muldiv_controller.sv | 138 +++++++++++++
 tb/tb_muldiv_controller.sv | 129 ++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide controller: op codes, FSM states, default iteration count.
package muldiv_pkg;
   typedef logic [1:0] op_t;

   localparam op_t OP_MULT  = 2'b00;
   localparam op_t OP_MULTU = 2'b01;
   localparam op_t OP_DIV   = 2'b10;
   localparam op_t OP_DIVU  = 2'b11;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int ITER_DEF = 32;
endpackage

// File: rtl/muldiv_controller_if.sv
// E-stage <-> mul/div controller bundle: operation request, flush, stall request and HI/LO write port.
interface muldiv_controller_if;
   import muldiv_pkg::*;

   logic        startE;
   op_t         opE;
   logic [31:0] srcaE;
   logic [31:0] srcbE;
   logic        FlushE;
   logic        StallMD;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        HiLoWrite;

   modport master (output startE, opE, srcaE, srcbE, FlushE,
                   input  StallMD, hi_o, lo_o, HiLoWrite);
   modport slave  (input  startE, opE, srcaE, srcbE, FlushE,
                   output StallMD, hi_o, lo_o, HiLoWrite);
endinterface

// File: rtl/div_step.sv
// One combinational restoring-divide iteration: shift in the next dividend bit, trial-subtract the divisor.
// Zero latency; no flow control.
module div_step (
   input  logic [32:0] rem_i,
   input  logic        bit_i,
   input  logic [31:0] dvs_i,
   output logic [32:0] rem_o,
   output logic        q_o
);
   logic [33:0] shifted;
   logic [33:0] diff;

   assign shifted = {rem_i, bit_i};
   assign diff    = shifted - {2'b00, dvs_i};
   // No borrow out of the top bit means the divisor fit.
   assign q_o     = ~diff[33];
   assign rem_o   = q_o ? diff[32:0] : shifted[32:0];
endmodule

// File: rtl/muldiv_controller.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer: ITER+1 stall cycles (1 for div-by-zero), HiLoWrite strobes in DONE.
// Stalls F/D/E via StallMD until the result is ready; FlushE cancels. MULDIV_FAST_MUL_EN selects a single-cycle multiplier.
module muldiv_controller
   import muldiv_pkg::*;
#(
   parameter int ITER = ITER_DEF
) (
   input  logic               clk,
   input  logic               resetn,
   muldiv_controller_if.slave md
);
   localparam logic [5:0] LAST = 6'(ITER - 1);

   logic [1:0]  state, state_n;
   logic [5:0]  cnt;
   logic        is_div, neg_res, neg_rem;
   logic [31:0] dvs;
   logic [63:0] acc;
   logic [32:0] rem;
   logic [31:0] res_hi, res_lo, hold_hi, hold_lo;

   logic        sgn_op, is_div_in, accept, dbz, go_done, wr;
   logic [31:0] abs_a, abs_b;

   assign sgn_op    = (md.opE == OP_MULT) | (md.opE == OP_DIV);
   assign is_div_in = (md.opE == OP_DIV) | (md.opE == OP_DIVU);
   assign abs_a     = (sgn_op & md.srcaE[31]) ? -md.srcaE : md.srcaE;
   assign abs_b     = (sgn_op & md.srcbE[31]) ? -md.srcbE : md.srcbE;
   assign accept    = md.startE & ~md.FlushE & (state == IDLE);
   assign dbz       = (md.srcbE == 32'd0);

`ifdef MULDIV_FAST_MUL_EN
   logic [63:0] ext_a, ext_b, fast_prod;
   assign ext_a     = {{32{sgn_op & md.srcaE[31]}}, md.srcaE};
   assign ext_b     = {{32{sgn_op & md.srcbE[31]}}, md.srcbE};
   assign fast_prod = ext_a * ext_b;
   assign go_done   = is_div_in ? dbz : 1'b1;
`else
   assign go_done   = is_div_in & dbz;
`endif

   // Multiply: acc = {partial product, remaining multiplier bits}, LSB-first shift-add.
   logic [32:0] mul_sum;
   logic [63:0] mul_nxt;
   assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, dvs} : 33'd0);
   assign mul_nxt = {mul_sum, acc[31:1]};

   // Divide: acc[31:0] shifts dividend bits out MSB-first and quotient bits in.
   logic [32:0] rem_nxt;
   logic        qbit;
   logic [31:0] quo_nxt;
   div_step u_div_step (
      .rem_i (rem),
      .bit_i (acc[31]),
      .dvs_i (dvs),
      .rem_o (rem_nxt),
      .q_o   (qbit)
   );
   assign quo_nxt = {acc[30:0], qbit};

   logic [63:0] prod_fix;
   logic [31:0] quo_fix, rem_fix;
   assign prod_fix = neg_res ? -mul_nxt : mul_nxt;
   assign quo_fix  = neg_res ? -quo_nxt : quo_nxt;
   assign rem_fix  = neg_rem ? -rem_nxt[31:0] : rem_nxt[31:0];

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = go_done ? DONE : CALC;
         CALC:    if (md.FlushE) state_n = IDLE;
                  else if (cnt == LAST) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         cnt     <= '0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         dvs     <= '0;
         acc     <= '0;
         rem     <= '0;
         res_hi  <= '0;
         res_lo  <= '0;
         hold_hi <= '0;
         hold_lo <= '0;
      end else begin
         state <= state_n;
         case (state)
            IDLE: if (accept) begin
               cnt     <= '0;
               is_div  <= is_div_in;
               neg_res <= sgn_op & (md.srcaE[31] ^ md.srcbE[31]);
               neg_rem <= sgn_op & md.srcaE[31];
               rem     <= '0;
               dvs     <= is_div_in ? abs_b : abs_a;
               acc     <= {32'd0, is_div_in ? abs_a : abs_b};
               // Divide-by-zero result; a real result overwrites it later.
               res_hi  <= md.srcaE;
               res_lo  <= '1;
`ifdef MULDIV_FAST_MUL_EN
               if (!is_div_in) {res_hi, res_lo} <= fast_prod;
`endif
            end
            CALC: begin
               cnt <= cnt + 6'd1;
               if (is_div) begin
                  acc[31:0] <= quo_nxt;
                  rem       <= rem_nxt;
               end else begin
                  acc <= mul_nxt;
               end
               if (cnt == LAST) begin
                  if (is_div) {res_hi, res_lo} <= {rem_fix, quo_fix};
                  else        {res_hi, res_lo} <= prod_fix;
               end
            end
            DONE: if (!md.FlushE) begin
               hold_hi <= res_hi;
               hold_lo <= res_lo;
            end
            default: ;
         endcase
      end
   end

   // A flush in DONE suppresses the write and leaves HI/LO showing the old values.
   assign wr           = (state == DONE) & ~md.FlushE;
   assign md.HiLoWrite = wr;
   assign md.hi_o      = wr ? res_hi : hold_hi;
   assign md.lo_o      = wr ? res_lo : hold_lo;
   assign md.StallMD   = accept | (state == CALC);
endmodule

// File: tb/tb_muldiv_controller.sv
// Directed self-checking bench for muldiv_controller: results, stall lengths, flush and async reset.
module tb_muldiv_controller;
   import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_STALL = 1;
`else
   localparam int MUL_STALL = 33;
`endif

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   checks = 0;
   int   errors = 0;

   muldiv_controller_if mif ();

   muldiv_controller #(.ITER(32)) dut (
      .clk    (clk),
      .resetn (resetn),
      .md     (mif.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Presents one op and holds it until HiLoWrite, then drops startE.
   task automatic run_op(input string tag, input op_t op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_stall, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int   stalls;
      logic got;
      logic stall_at_wr;
      logic [31:0] hi, lo;
      stalls = 0; got = 1'b0; stall_at_wr = 1'b1; hi = '0; lo = '0;
      @(negedge clk);
      mif.startE = 1'b1; mif.opE = op; mif.srcaE = a; mif.srcbE = b;
      for (int c = 0; c < 100 && !got; c++) begin
         #1;
         if (mif.HiLoWrite) begin
            got = 1'b1; hi = mif.hi_o; lo = mif.lo_o; stall_at_wr = mif.StallMD;
         end else if (mif.StallMD) begin
            stalls++;
         end
         @(negedge clk);
      end
      mif.startE = 1'b0;
      chk({tag, " write_seen"}, 64'(got), 64'd1);
      chk({tag, " stall_cycles"}, 64'(stalls), 64'(exp_stall));
      chk({tag, " stall_in_done"}, 64'(stall_at_wr), 64'd0);
      chk({tag, " hi"}, 64'(hi), 64'(exp_hi));
      chk({tag, " lo"}, 64'(lo), 64'(exp_lo));
   endtask

   initial begin
      int writes;
      mif.startE = 1'b0; mif.opE = OP_MULT; mif.srcaE = '0; mif.srcbE = '0; mif.FlushE = 1'b0;

      #12;
      chk("reset stall", 64'(mif.StallMD), 64'd0);
      chk("reset hilowrite", 64'(mif.HiLoWrite), 64'd0);
      chk("reset hi", 64'(mif.hi_o), 64'd0);
      chk("reset lo", 64'(mif.lo_o), 64'd0);
      @(negedge clk);
      resetn = 1'b1;

      run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);
      run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
      run_op("mult_m3_5", OP_MULT, 32'hFFFF_FFFD, 32'd5, MUL_STALL, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run_op("multu_max_2", OP_MULTU, 32'hFFFF_FFFF, 32'd2, MUL_STALL, 32'd1, 32'hFFFF_FFFE);
      run_op("multu_shift", OP_MULTU, 32'h1234_5678, 32'h10, MUL_STALL, 32'd1, 32'h2345_6780);
      run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF);
      run_op("div_m9_0", OP_DIV, 32'hFFFF_FFF7, 32'd0, 1, 32'hFFFF_FFF7, 32'hFFFF_FFFF);

      // Flush and start together in IDLE: nothing starts.
      @(negedge clk);
      mif.startE = 1'b1; mif.FlushE = 1'b1; mif.opE = OP_DIVU; mif.srcaE = 32'd9; mif.srcbE = 32'd3;
      #1 chk("flush_start stall", 64'(mif.StallMD), 64'd0);
      @(negedge clk);
      mif.startE = 1'b0; mif.FlushE = 1'b0;
      #1 chk("flush_start idle", 64'(mif.StallMD | mif.HiLoWrite), 64'd0);

      // Flush at CALC cycle 10 of a DIV.
      @(negedge clk);
      mif.startE = 1'b1; mif.opE = OP_DIV; mif.srcaE = 32'd1000; mif.srcbE = 32'd3;
      repeat (10) @(negedge clk);
      #1 chk("calc10 stall", 64'(mif.StallMD), 64'd1);
      mif.FlushE = 1'b1; mif.startE = 1'b0;
      @(negedge clk);
      mif.FlushE = 1'b0;
      #1;
      chk("post_flush stall", 64'(mif.StallMD), 64'd0);
      chk("post_flush hi", 64'(mif.hi_o), 64'hFFFF_FFF7);
      chk("post_flush lo", 64'(mif.lo_o), 64'hFFFF_FFFF);
      writes = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         #1 if (mif.HiLoWrite) writes++;
      end
      chk("post_flush writes", 64'(writes), 64'd0);
      run_op("div_1000_m3", OP_DIV, 32'd1000, 32'hFFFF_FFFD, 33, 32'd1, 32'hFFFF_FEB3);

      // Async reset mid-CALC.
      @(negedge clk);
      mif.startE = 1'b1; mif.opE = OP_DIVU; mif.srcaE = 32'd77; mif.srcbE = 32'd5;
      repeat (5) @(negedge clk);
      mif.startE = 1'b0;
      #1 resetn = 1'b0;
      #1;
      chk("rst_mid stall", 64'(mif.StallMD), 64'd0);
      chk("rst_mid hilowrite", 64'(mif.HiLoWrite), 64'd0);
      chk("rst_mid hi", 64'(mif.hi_o), 64'd0);
      chk("rst_mid lo", 64'(mif.lo_o), 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      #1 chk("rst_release idle", 64'(mif.StallMD | mif.HiLoWrite), 64'd0);
      run_op("mult_m4_m6", OP_MULT, 32'hFFFF_FFFC, 32'hFFFF_FFFA, MUL_STALL, 32'd0, 32'd24);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
